prio_event_encoder: RTL and testbench

- Parametrised, registered successor to the 4-to-3 priority encoder.
- Captures single-cycle request pulses on an N-bit vector into a sticky pending set and encodes one pending bit at a time as a 1-based index (0 = none, MSB-first).
- The encoded index is offered on a valid/ready output; the priority mode is selectable at run time between fixed and round-robin.
- Sits between raw event sources (buttons, sensors, timer flags) and the control FSMs that consume them one at a time.

---
 rtl/prio_event_pkg.sv | 30 +++
 rtl/prio_pick.sv | 66 ++++++
 rtl/prio_event_encoder.sv | 92 +++++++++
 tb/tb_prio_event_encoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prio_event_pkg
// Description : Shared constants and helpers for the priority event encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package prio_event_pkg;

   // Priority mode selector values
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Output code meaning "no event granted"
   localparam int CODE_NONE = 0;

   // Ceiling log2, usable in constant expressions (clog2(1) = 0)
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : prio_pick
// Description : Combinational selector. Finds one set bit of vec, scanning
//               downward. Fixed mode starts at N-1; round-robin mode starts at
//               'start' and wraps from bit 0 to bit N-1. Implemented as
//               rotate -> descending scan -> un-rotate.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_pick
   import prio_event_pkg::*;
#(
   parameter int N     = 8,
   parameter int OUT_W = clog2(N + 1)
) (
   input  logic [N-1:0]     vec,
   input  logic [OUT_W-1:0] start,
   input  logic             mode,
   output logic             found,
   output logic [OUT_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   logic [N-1:0] rot;
   int           base;
   int           pos;
   int           sel;

   // Rotate so the first bit to examine lands at N-1, take the highest set
   // bit of the rotated vector, then map its position back to vec.
   always_comb begin
      rot    = '0;
      found  = 1'b0;
      pos    = 0;
      idx    = '0;
      onehot = '0;

      if (mode == MODE_RR) begin
         base = int'(start);
      end else begin
         base = N - 1;
      end
      if (base >= N) begin
         base = N - 1;
      end

      for (int j = 0; j < N; j++) begin
         rot[j] = vec[(j + base + 1) % N];
      end

      for (int j = 0; j < N; j++) begin
         if (rot[j]) begin
            found = 1'b1;
            pos   = j;
         end
      end

      sel = (pos + base + 1) % N;
      if (found) begin
         idx    = OUT_W'(sel);
         onehot = N'(1) << sel;
      end
   end

endmodule
`default_nettype wire

// File: rtl/prio_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : prio_event_encoder
// Description : Captures request pulses into a sticky pending set and hands
//               out one pending event at a time as a 1-based code (MSB-first
//               fixed priority or round-robin) on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_event_encoder
   import prio_event_pkg::*;
#(
   parameter  int N     = 8,
   localparam int OUT_W = clog2(N + 1)
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             mode,
   input  logic [N-1:0]     req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_code,
   output logic [N-1:0]     out_onehot,
   output logic             pend_any,
   output logic             coalesce
);

   logic [N-1:0]     pending;
   logic [OUT_W-1:0] last;
   logic [OUT_W-1:0] search_start;
   logic             load;
   logic             pick_found;
   logic [OUT_W-1:0] pick_idx;
   logic [N-1:0]     pick_onehot;
   logic [N-1:0]     pop_mask;

   // Output buffer may take a new event when empty or being consumed
   assign load = !out_valid | out_ready;

   // Round-robin search begins one below the last grant, wrapping to N-1
   assign search_start = (last == '0) ? OUT_W'(N - 1) : last - OUT_W'(1);

   // Only a bit actually moved into the output buffer leaves pending
   assign pop_mask = (load && pick_found) ? pick_onehot : '0;

   assign pend_any = (|pending) | out_valid;

   prio_pick #(
      .N     (N),
      .OUT_W (OUT_W)
   ) u_pick (
      .vec    (pending),
      .start  (search_start),
      .mode   (mode),
      .found  (pick_found),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   // Pending set: new requests win over the pop of the same bit
   always_ff @(posedge clk) begin
      if (reset_p) begin
         pending  <= '0;
         coalesce <= 1'b0;
      end else begin
         pending  <= (pending & ~pop_mask) | req;
         coalesce <= |(req & pending & ~pop_mask);
      end
   end

   // Output buffer and round-robin pointer, reloaded whenever load is true
   always_ff @(posedge clk) begin
      if (reset_p) begin
         out_valid  <= 1'b0;
         out_code   <= OUT_W'(CODE_NONE);
         out_onehot <= '0;
         last       <= '0;
      end else if (load) begin
         if (pick_found) begin
            out_valid  <= 1'b1;
            out_code   <= pick_idx + OUT_W'(1);
            out_onehot <= pick_onehot;
            last       <= pick_idx;
         end else begin
            out_valid  <= 1'b0;
            out_code   <= OUT_W'(CODE_NONE);
            out_onehot <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prio_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_event_encoder
// Description : Directed self-checking bench for prio_event_encoder (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_event_encoder;

   localparam int N     = 8;
   localparam int OUT_W = 4;

   logic             clk;
   logic             reset_p;
   logic             mode;
   logic [N-1:0]     req;
   logic             out_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_code;
   logic [N-1:0]     out_onehot;
   logic             pend_any;
   logic             coalesce;

   int n_assert = 0;
   int n_fail   = 0;

   prio_event_encoder #(.N(N)) dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .mode       (mode),
      .req        (req),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_code   (out_code),
      .out_onehot (out_onehot),
      .pend_any   (pend_any),
      .coalesce   (coalesce)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling/driving
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_p   = 1'b1;
      mode      = 1'b0;
      req       = 8'hFF;
      out_ready = 1'b1;

      // Reset with requests present: everything stays clear
      cyc();
      cyc();
      chk("rst_valid",   out_valid,  0);
      chk("rst_code",    out_code,   0);
      chk("rst_onehot",  out_onehot, 0);
      chk("rst_pend",    pend_any,   0);
      chk("rst_coal",    coalesce,   0);

      reset_p = 1'b0;
      req     = 8'h00;
      cyc();
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_pend",  pend_any,  0);

      // First request: grant appears two edges later
      req = 8'h80;
      cyc();
      req = 8'h00;
      chk("lat1_valid", out_valid, 0);
      chk("lat1_pend",  pend_any,  1);
      cyc();
      chk("lat2_valid",  out_valid,  1);
      chk("lat2_code",   out_code,   8);
      chk("lat2_onehot", out_onehot, 8'h80);
      cyc();
      chk("lat3_valid", out_valid, 0);
      chk("lat3_code",  out_code,  0);
      chk("lat3_pend",  pend_any,  0);

      // Fixed priority drain of 1010_0100
      req = 8'hA4;
      cyc();
      req = 8'h00;
      chk("fx_t1_valid", out_valid, 0);
      cyc();
      chk("fx_code8", out_code, 8);
      cyc();
      chk("fx_code6", out_code, 6);
      chk("fx_oh6",   out_onehot, 8'h20);
      cyc();
      chk("fx_code3", out_code, 3);
      cyc();
      chk("fx_end_valid", out_valid, 0);
      chk("fx_end_code",  out_code,  0);

      // Holding under back-pressure while pending accumulates
      out_ready = 1'b0;
      req = 8'h01;
      cyc();
      req = 8'h80;
      cyc();
      req = 8'h00;
      chk("hold_code0", out_code,   1);
      chk("hold_oh0",   out_onehot, 8'h01);
      for (int k = 1; k < 5; k++) begin
         cyc();
         chk("hold_valid", out_valid, 1);
         chk("hold_code",  out_code,  1);
      end
      chk("hold_pend", pend_any, 1);
      out_ready = 1'b1;
      cyc();
      chk("hold_next8", out_code, 8);
      cyc();
      chk("hold_done_valid", out_valid, 0);
      chk("hold_done_code",  out_code,  0);

      // Fresh reset so the round-robin pointer starts at 0
      reset_p = 1'b1;
      cyc();
      reset_p = 1'b0;

      // Round-robin with all requests held: 8,7,...,1,8
      mode = 1'b1;
      req  = 8'hFF;
      cyc();
      chk("rr_t1_valid", out_valid, 0);
      for (int k = 0; k < 9; k++) begin
         cyc();
         chk("rr_code", out_code, (k == 8) ? 8 : 8 - k);
         if (k == 0) chk("rr_coal", coalesce, 1);
      end

      // Switch to fixed: bit 7 re-set every cycle keeps winning
      mode = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("fx_ff_code", out_code, 8);
      end

      // Clean up via reset
      req     = 8'h00;
      reset_p = 1'b1;
      cyc();
      reset_p = 1'b0;
      chk("rst2_valid", out_valid, 0);
      chk("rst2_pend",  pend_any,  0);

      // Coalesce: repeat bit 2 while it is still pending
      out_ready = 1'b0;
      req = 8'h01;
      cyc();
      req = 8'h00;
      cyc();
      chk("co_hold1", out_code, 1);
      req = 8'h04;
      cyc();
      req = 8'h00;
      chk("co_t_coal", coalesce, 0);
      cyc();
      chk("co_t1_coal", coalesce, 0);
      cyc();
      chk("co_t2_coal", coalesce, 0);
      req = 8'h04;
      cyc();
      req = 8'h00;
      chk("co_t3_coal", coalesce, 1);
      cyc();
      chk("co_t4_coal", coalesce, 0);
      chk("co_still1",  out_code, 1);
      out_ready = 1'b1;
      cyc();
      chk("co_code3", out_code, 3);
      cyc();
      chk("co_once_valid", out_valid, 0);
      chk("co_once_code",  out_code,  0);

      // Reset mid-operation discards held and pending events
      out_ready = 1'b0;
      req = 8'h01;
      cyc();
      req = 8'h00;
      cyc();
      req = 8'h3C;
      cyc();
      req = 8'h00;
      chk("mid_valid", out_valid, 1);
      chk("mid_pend",  pend_any,  1);
      reset_p = 1'b1;
      cyc();
      reset_p = 1'b0;
      out_ready = 1'b1;
      chk("mid_rst_valid",  out_valid,  0);
      chk("mid_rst_code",   out_code,   0);
      chk("mid_rst_onehot", out_onehot, 0);
      chk("mid_rst_pend",   pend_any,   0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("mid_stale_valid", out_valid, 0);
         chk("mid_stale_code",  out_code,  0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
